// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: machine word, opcode field and fetch-stage state.
// The optional FETCH_HALT_DETECT_EN build of fetch_stage uses HALT from here.
package cpu_types_pkg;

   localparam int WORD_W   = 32;
   localparam int OPCODE_W = 6;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [OPCODE_W-1:0] {
      RTYPE = 6'h00,
      J     = 6'h02,
      JAL   = 6'h03,
      BEQ   = 6'h04,
      BNE   = 6'h05,
      ADDI  = 6'h08,
      ADDIU = 6'h09,
      LW    = 6'h23,
      SW    = 6'h2B,
      HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      word_t instr;
      word_t pcplus4;
   } skid_t;

   function automatic opcode_t opcode_of(input word_t w);
      return opcode_t'(w[31:26]);
   endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous active-low reset to PC_INIT,
// loads pc_next only when load is asserted.
module pc_reg
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        load,
   input  logic [31:0] pc_next,
   output logic [31:0] pc
);

   word_t pc_value_reg;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         pc_value_reg <= PC_INIT;
      end else if (load) begin
         pc_value_reg <= pc_next;
      end
   end

   assign pc = pc_value_reg;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, icache request, IF/ID register and a
// one-entry skid buffer. Define FETCH_HALT_DETECT_EN to freeze fetch on HALT.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_d,
   output logic [31:0] pcplus4_d,
   output logic        valid_d,
   output logic        halt_f
);

   fetch_state_t state_reg, state_next;
   word_t        instr_reg, instr_next;
   word_t        pcplus4_reg, pcplus4_next;
   logic         valid_reg, valid_next;
   skid_t        skid_reg, skid_next;

   word_t        pc;
   word_t        pc_plus4;
   word_t        pc_next;
   logic         pc_load;

   pc_reg #(
      .PC_INIT (PC_INIT)
   ) u_pc_reg (
      .CLK     (CLK),
      .nRST    (nRST),
      .load    (pc_load),
      .pc_next (pc_next),
      .pc      (pc)
   );

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      state_next   = state_reg;
      instr_next   = instr_reg;
      pcplus4_next = pcplus4_reg;
      valid_next   = valid_reg;
      skid_next    = skid_reg;
      pc_load      = 1'b0;
      pc_next      = pc_plus4;

      if (redirect) begin
         // Any word fetched this cycle is wrong-path; it is treated like a miss.
         pc_load    = 1'b1;
         pc_next    = redirect_pc;
         state_next = FETCH;
         skid_next  = '0;
         if (flush_d) begin
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
         end else if (!stall_d) begin
            instr_next = '0;
            valid_next = 1'b0;
         end
      end else if (flush_d) begin
         if (state_reg != HALTED) begin
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
            skid_next    = '0;
            state_next   = FETCH;
         end
      end else if (stall_d) begin
         if (state_reg == FETCH && ihit) begin
            skid_next  = '{instr: iload, pcplus4: pc_plus4};
            state_next = HOLD;
         end
      end else begin
         case (state_reg)
            FETCH: begin
               if (ihit) begin
                  instr_next   = iload;
                  pcplus4_next = pc_plus4;
                  valid_next   = 1'b1;
                  pc_load      = 1'b1;
               end else begin
                  instr_next = '0;
                  valid_next = 1'b0;
               end
            end
            HOLD: begin
               // PC was held at the skid word's address, so PC+4 matches skid.
               instr_next   = skid_reg.instr;
               pcplus4_next = skid_reg.pcplus4;
               valid_next   = 1'b1;
               pc_load      = 1'b1;
               skid_next    = '0;
               state_next   = FETCH;
            end
            default: begin
            end
         endcase
      end

`ifdef FETCH_HALT_DETECT_EN
      if (!redirect && !flush_d && !stall_d &&
          ((state_reg == FETCH && ihit) || state_reg == HOLD) &&
          opcode_of(instr_next) == HALT) begin
         state_next = HALTED;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_reg   <= FETCH;
         instr_reg   <= '0;
         pcplus4_reg <= '0;
         valid_reg   <= 1'b0;
         skid_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         instr_reg   <= instr_next;
         pcplus4_reg <= pcplus4_next;
         valid_reg   <= valid_next;
         skid_reg    <= skid_next;
      end
   end

`ifdef FETCH_HALT_DETECT_EN
   logic halt_reg;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         halt_reg <= 1'b0;
      end else begin
         halt_reg <= (state_next == HALTED);
      end
   end

   assign halt_f = halt_reg;
`else
   assign halt_f = 1'b0;
`endif

   assign imemREN   = nRST && (state_reg == FETCH);
   assign imemaddr  = pc;
   assign instr_d   = instr_reg;
   assign pcplus4_d = pcplus4_reg;
   assign valid_d   = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, redirect,
// flush, PC wrap and HALT handling, checked with immediate assertions.
module tb_fetch_stage;

   logic        CLK;
   logic        nRST;
   logic        ihit;
   logic [31:0] iload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        stall_d;
   logic        flush_d;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;
   logic        halt_f;

   int checks   = 0;
   int failures = 0;

   fetch_stage #(
      .PC_INIT (32'h0000_0000)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .iload       (iload),
      .imemREN     (imemREN),
      .imemaddr    (imemaddr),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_d     (instr_d),
      .pcplus4_d   (pcplus4_d),
      .valid_d     (valid_d),
      .halt_f      (halt_f)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string name);
      @(posedge CLK);
      #1;
      $display("step %-12s addr=%h ren=%0d instr=%h pc4=%h v=%0d halt=%0d",
               name, imemaddr, imemREN, instr_d, pcplus4_d, valid_d, halt_f);
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; iload = '0; stall_d = 1'b0;
      flush_d = 1'b0; redirect = 1'b0; redirect_pc = '0;

      #1;
      check("ren_in_rst", imemREN, 0);
      tick("reset");
      tick("reset");
      check("rst_valid", valid_d, 0);
      check("rst_instr", instr_d, 0);
      check("rst_pc4", pcplus4_d, 0);
      check("rst_addr", imemaddr, 0);
      check("rst_halt", halt_f, 0);
      nRST = 1'b1;
      #1;
      check("ren_after_rst", imemREN, 1);

      // Streaming fetch with no stalls
      ihit = 1'b1; iload = 32'h2001_0005;
      tick("stream0");
      check("s0_instr", instr_d, 32'h2001_0005);
      check("s0_pc4", pcplus4_d, 32'h4);
      check("s0_valid", valid_d, 1);
      check("s0_addr", imemaddr, 32'h4);
      tick("stream1");
      check("s1_addr", imemaddr, 32'h8);
      check("s1_valid", valid_d, 1);
      tick("stream2");
      check("s2_addr", imemaddr, 32'hC);
      check("s2_pc4", pcplus4_d, 32'hC);
      iload = 32'h8C22_0000;
      tick("stream3");
      check("s3_instr", instr_d, 32'h8C22_0000);
      check("s3_addr", imemaddr, 32'h10);

      // Stall at PC 0x10 for three cycles
      iload = 32'hAC23_0004; stall_d = 1'b1;
      tick("stall0");
      check("st0_ren", imemREN, 0);
      check("st0_addr", imemaddr, 32'h10);
      check("st0_instr_held", instr_d, 32'h8C22_0000);
      check("st0_valid", valid_d, 1);
      ihit = 1'b0;
      tick("stall1");
      tick("stall2");
      check("st2_ren", imemREN, 0);
      check("st2_addr", imemaddr, 32'h10);
      stall_d = 1'b0;
      tick("release");
      check("rel_instr", instr_d, 32'hAC23_0004);
      check("rel_pc4", pcplus4_d, 32'h14);
      check("rel_addr", imemaddr, 32'h14);
      check("rel_ren", imemREN, 1);

      // Redirect discards same-cycle fetch
      ihit = 1'b1; iload = 32'hDEAD_BEEF; redirect = 1'b1; redirect_pc = 32'h400;
      tick("redirect");
      check("rd_addr", imemaddr, 32'h400);
      check("rd_instr", instr_d, 32'h0);
      check("rd_valid", valid_d, 0);
      redirect = 1'b0; iload = 32'h2442_0001;
      tick("target");
      check("tg_instr", instr_d, 32'h2442_0001);
      check("tg_pc4", pcplus4_d, 32'h404);
      check("tg_addr", imemaddr, 32'h404);

      // Flush overrides stall; word refetched
      iload = 32'h0043_1020; flush_d = 1'b1; stall_d = 1'b1;
      tick("flush_stall");
      check("fl_valid", valid_d, 0);
      check("fl_instr", instr_d, 0);
      check("fl_pc4", pcplus4_d, 0);
      check("fl_addr", imemaddr, 32'h404);
      check("fl_ren", imemREN, 1);
      flush_d = 1'b0; stall_d = 1'b0;
      tick("refetch");
      check("rf_instr", instr_d, 32'h0043_1020);
      check("rf_pc4", pcplus4_d, 32'h408);
      check("rf_addr", imemaddr, 32'h408);

      // Flush while holding a skid word
      iload = 32'h1111_1111; stall_d = 1'b1;
      tick("hold");
      check("hd_ren", imemREN, 0);
      flush_d = 1'b1;
      tick("flush_hold");
      check("fh_ren", imemREN, 1);
      check("fh_valid", valid_d, 0);
      check("fh_addr", imemaddr, 32'h408);
      flush_d = 1'b0; stall_d = 1'b0; iload = 32'h2222_2222;
      tick("after_fh");
      check("afh_instr", instr_d, 32'h2222_2222);
      check("afh_pc4", pcplus4_d, 32'h40C);

      // PC wrap at top of address space
      ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick("to_top");
      check("top_addr", imemaddr, 32'hFFFF_FFFC);
      redirect = 1'b0; ihit = 1'b1; iload = 32'h3333_3333;
      tick("wrap");
      check("wr_instr", instr_d, 32'h3333_3333);
      check("wr_pc4", pcplus4_d, 32'h0);
      check("wr_addr", imemaddr, 32'h0);

      // Miss without stall inserts a bubble
      ihit = 1'b0;
      tick("miss");
      check("ms_valid", valid_d, 0);
      check("ms_instr", instr_d, 0);
      check("ms_addr", imemaddr, 32'h0);

      // HALT word at PC 0
      ihit = 1'b1; iload = 32'hFC00_0000;
      tick("halt_word");
      check("hw_instr", instr_d, 32'hFC00_0000);
      check("hw_addr", imemaddr, 32'h4);
      ihit = 1'b0;
      tick("post_halt");
`ifdef FETCH_HALT_DETECT_EN
      check("ph_halt", halt_f, 1);
      check("ph_ren", imemREN, 0);
      check("ph_instr", instr_d, 32'hFC00_0000);
`else
      check("ph_halt", halt_f, 0);
      check("ph_ren", imemREN, 1);
      check("ph_valid", valid_d, 0);
`endif
      redirect = 1'b1; redirect_pc = 32'h80;
      tick("exit_redir");
      check("ex_halt", halt_f, 0);
      check("ex_addr", imemaddr, 32'h80);
      check("ex_ren", imemREN, 1);
      redirect = 1'b0; ihit = 1'b1; iload = 32'h0800_0000;
      tick("fetch_80");
      check("f80_instr", instr_d, 32'h0800_0000);
      check("f80_pc4", pcplus4_d, 32'h84);

      // Mid-run reset
      nRST = 1'b0;
      #1;
      check("mr_ren_comb", imemREN, 0);
      tick("mid_reset");
      check("mr_addr", imemaddr, 32'h0);
      check("mr_valid", valid_d, 0);
      check("mr_instr", instr_d, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
